// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types.
//   parity_t, stop_bits_t   line framing options
//   uart_rx_entry_t         one received frame as buffered for the consumer
//   uart_rx_state_e         receiver FSM states
//   clamp_bits()            forces a data-bit count into the legal 5..8 range
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic {
    STOP_1 = 1'b0,
    STOP_2 = 1'b1
  } stop_bits_t;

  typedef struct packed {
    logic [7:0] data;
    logic       parity_err;
    logic       frame_err;
  } uart_rx_entry_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_BREAK  = 3'd6
  } uart_rx_state_e;

  function automatic logic [3:0] clamp_bits(input logic [3:0] n);
    if (n < 4'd5) return 4'd5;
    if (n > 4'd8) return 4'd8;
    return n;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received frames.
//   clk, rst   clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata write request; accepted when not full, or when full with a pop
//   pop        read request; ignored when empty
//   rdata      head entry, all zeros while empty
//   full/empty occupancy flags
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with a frame FIFO.
//   clk, rst          clock, asynchronous active-high reset
//   rx                asynchronous serial line, idle high
//   baud_div          oversample tick period in clk cycles minus 1
//   num_data_bits     5..8 data bits (clamped), latched at the start-bit sample
//   stop_bits, parity framing, latched at the start-bit sample
//   m_data/m_parity_err/m_frame_err/m_valid/m_ready  head-of-FIFO stream;
//                     an entry transfers on a cycle where m_valid and m_ready
//                     are both high, and the head holds steady otherwise
//   rx_busy           FSM outside S_IDLE
//   overrun           one-cycle pulse when a frame is dropped on a full FIFO
//   break_det         one-cycle pulse on a break (only with UART_RX_BREAK_EN)
// Build option: define UART_RX_BREAK_EN to enable break detection; otherwise a
// break frame is delivered as 0x00 with a frame error.
// The FSM state is visible as state_q for debug.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] baud_div,
  input  logic [3:0]  num_data_bits,
  input  stop_bits_t  stop_bits,
  input  parity_t     parity,
  output logic [7:0]  m_data,
  output logic        m_parity_err,
  output logic        m_frame_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        rx_busy,
  output logic        overrun,
  output logic        break_det
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] HALF_M1 = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] FULL_M1 = OS_W'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  uart_rx_state_e state_q, state_d;
  logic [15:0]     div_cnt_q, div_cnt_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [3:0]      nbits_q, nbits_d;
  logic            stop2_q, stop2_d;
  parity_t         par_q, par_d;
  logic [7:0]      data_q, data_d;
  logic            par_acc_q, par_acc_d, perr_q, perr_d, ferr_q, ferr_d;
  logic            overrun_q, overrun_d;
  logic            rx_s, tick, half_smp, full_smp, push, fifo_full, fifo_empty;
  uart_rx_entry_t  push_entry, head;
`ifdef UART_RX_BREAK_EN
  logic            par_bit_q, par_bit_d, break_q, break_d;
`endif

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign tick     = (div_cnt_q == baud_div);
  assign half_smp = tick && (os_cnt_q == HALF_M1);
  assign full_smp = tick && (os_cnt_q == FULL_M1);

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    nbits_d    = nbits_q;
    stop2_d    = stop2_q;
    par_d      = par_q;
    data_d     = data_q;
    par_acc_d  = par_acc_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    push       = 1'b0;
`ifdef UART_RX_BREAK_EN
    par_bit_d  = par_bit_q;
    break_d    = 1'b0;
`endif
    // Divider held at zero while idle so the first tick is phased to the start edge.
    if (state_q == S_IDLE || tick) div_cnt_d = '0;
    else                           div_cnt_d = div_cnt_q + 16'd1;
    if (tick) os_cnt_d = os_cnt_q + OS_W'(1);

    case (state_q)
      S_IDLE: begin
        os_cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // Any high tick before mid-bit marks a glitch; give up early.
        if (tick && rx_s) state_d = S_IDLE;
        else if (half_smp) begin
          state_d   = S_DATA;
          os_cnt_d  = '0;
          bit_idx_d = '0;
          nbits_d   = clamp_bits(num_data_bits);
          stop2_d   = (stop_bits == STOP_2);
          par_d     = parity;
          data_d    = '0;
          par_acc_d = 1'b0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
`ifdef UART_RX_BREAK_EN
          par_bit_d = 1'b0;
`endif
        end
      end
      S_DATA: begin
        if (full_smp) begin
          os_cnt_d          = '0;
          data_d[bit_idx_q] = rx_s;
          par_acc_d         = par_acc_q ^ rx_s;
          if ({1'b0, bit_idx_q} == nbits_q - 4'd1)
            state_d = (par_q == PAR_NONE) ? S_STOP1 : S_PARITY;
          else
            bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (full_smp) begin
          os_cnt_d = '0;
          // Odd parity expects the XOR over data+parity to be 1, even expects 0.
          perr_d   = (par_q == PAR_ODD) ? !(par_acc_q ^ rx_s) : (par_acc_q ^ rx_s);
`ifdef UART_RX_BREAK_EN
          par_bit_d = rx_s;
`endif
          state_d  = S_STOP1;
        end
      end
      S_STOP1: begin
        if (full_smp) begin
          os_cnt_d = '0;
          ferr_d   = !rx_s;
`ifdef UART_RX_BREAK_EN
          if (data_q == '0 && !par_bit_q && !rx_s) begin
            break_d = 1'b1;
            state_d = S_BREAK;
          end else
`endif
          if (stop2_q) state_d = S_STOP2;
          else begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (full_smp) begin
          ferr_d  = ferr_q | !rx_s;
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    push_entry = '{data: data_q, parity_err: perr_d, frame_err: ferr_d};
    overrun_d  = push && fifo_full && !(m_valid && m_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      nbits_q   <= 4'd8;
      stop2_q   <= 1'b0;
      par_q     <= PAR_NONE;
      data_q    <= '0;
      par_acc_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_BREAK_EN
      par_bit_q <= 1'b0;
      break_q   <= 1'b0;
`endif
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      nbits_q   <= nbits_d;
      stop2_q   <= stop2_d;
      par_q     <= par_d;
      data_q    <= data_d;
      par_acc_q <= par_acc_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
`ifdef UART_RX_BREAK_EN
      par_bit_q <= par_bit_d;
      break_q   <= break_d;
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH($bits(uart_rx_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(push_entry),
    .pop  (m_valid && m_ready),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign m_valid      = !fifo_empty;
  assign m_data       = head.data;
  assign m_parity_err = head.parity_err;
  assign m_frame_err  = head.frame_err;
  assign rx_busy      = (state_q != S_IDLE);
  assign overrun      = overrun_q;
`ifdef UART_RX_BREAK_EN
  assign break_det    = break_q;
`else
  assign break_det    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int OS   = 16;
  localparam int BDIV = 3;
  localparam int BIT  = OS * (BDIV + 1);

  logic        clk, rst, rx, m_ready;
  logic [15:0] baud_div;
  logic [3:0]  num_data_bits;
  stop_bits_t  stop_bits;
  parity_t     parity;
  logic [7:0]  m_data;
  logic        m_parity_err, m_frame_err, m_valid, rx_busy, overrun, break_det;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int got_rd  = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;

  uart_rx_os #(.OVERSAMPLE(OS), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div),
    .num_data_bits(num_data_bits), .stop_bits(stop_bits), .parity(parity),
    .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
    .m_valid(m_valid), .m_ready(m_ready), .rx_busy(rx_busy),
    .overrun(overrun), .break_det(break_det)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor: records accepted entries and pulses ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) got_q.push_back({m_data, m_parity_err, m_frame_err});
      if (overrun)   ovr_cnt <= ovr_cnt + 1;
      if (break_det) brk_cnt <= brk_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_entries(input int n, input int budget);
    int k = 0;
    while ((got_q.size() - got_rd) < n && k < budget) begin
      hold(1);
      k++;
    end
  endtask

  function automatic int eff_bits(input int nb);
    return (nb < 5) ? 5 : ((nb > 8) ? 8 : nb);
  endfunction

  // Reference: what the consumer should see for a frame built from these rules.
  function automatic logic [9:0] model(input logic [7:0] val, input int nb, input parity_t par,
                                       input logic two, input logic bad, input logic [1:0] stop_low);
    logic [7:0] d;
    d = val & 8'((1 << eff_bits(nb)) - 1);
    return {d, (par != PAR_NONE) && bad, stop_low[0] | (two & stop_low[1])};
  endfunction

  function automatic parity_t pick_par(input int r);
    return (r == 0) ? PAR_NONE : ((r == 1) ? PAR_ODD : PAR_EVEN);
  endfunction

  task automatic send_frame(input logic [7:0] val, input int nb, input parity_t par,
                            input logic two, input logic bad, input logic [1:0] stop_low,
                            input logic scramble);
    logic p;
    logic pb;
    num_data_bits = 4'(nb);
    parity        = par;
    stop_bits     = two ? STOP_2 : STOP_1;
    rx = 1'b0;
    hold(BIT);
    if (scramble) begin
      num_data_bits = 4'($urandom_range(5, 7));
      parity        = pick_par($urandom_range(1, 2));
      stop_bits     = STOP_2;
    end
    p = 1'b0;
    for (int i = 0; i < eff_bits(nb); i++) begin
      rx = val[i];
      p  = p ^ val[i];
      hold(BIT);
    end
    if (par != PAR_NONE) begin
      pb = (par == PAR_EVEN) ? p : ~p;
      rx = bad ? ~pb : pb;
      hold(BIT);
    end
    rx = ~stop_low[0];
    hold(BIT);
    if (two) begin
      rx = ~stop_low[1];
      hold(BIT);
    end
    rx = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    hold(5);
    checks++;
    if ({m_valid, overrun, break_det, rx_busy, m_data, m_parity_err, m_frame_err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {m_valid, overrun, break_det, rx_busy, m_data, m_parity_err, m_frame_err});
    end
    rst = 1'b0;
    hold(10);
    checks++;
    if (rx_busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: rx_busy=%b m_valid=%b expected 0 0", rx_busy, m_valid);
    end
  endtask

  task automatic test_8n1();
    int o0;
    logic [9:0] e;
    o0 = ovr_cnt;
    exp_q.push_back(model(8'hA5, 8, PAR_NONE, 1'b0, 1'b0, 2'b00));
    send_frame(8'hA5, 8, PAR_NONE, 1'b0, 1'b0, 2'b00, 1'b0);
    wait_entries(1, 2 * BIT);
    hold(BIT);
    checks++;
    if (got_q.size() - got_rd != 1) begin
      errors++;
      $display("FAIL 8n1_count: got %0d entries expected 1", got_q.size() - got_rd);
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[got_rd] !== e) begin
        errors++;
        $display("FAIL 8n1_entry: got %h expected %h", got_q[got_rd], e);
      end
      got_rd++;
    end
    checks++;
    if (ovr_cnt != o0) begin
      errors++;
      $display("FAIL 8n1_overrun: got %0d pulses expected 0", ovr_cnt - o0);
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic test_parity_7e2();
    logic [9:0] e;
    e = model(8'h55, 7, PAR_EVEN, 1'b1, 1'b1, 2'b00);
    send_frame(8'h55, 7, PAR_EVEN, 1'b1, 1'b1, 2'b00, 1'b0);
    wait_entries(1, 2 * BIT);
    checks++;
    if (got_q.size() - got_rd != 1) begin
      errors++;
      $display("FAIL 7e2_count: got %0d entries expected 1", got_q.size() - got_rd);
    end else begin
      checks++;
      if (got_q[got_rd] !== e) begin
        errors++;
        $display("FAIL 7e2_entry: got %h expected %h", got_q[got_rd], e);
      end
    end
    got_rd = got_q.size();
  endtask

  task automatic test_glitch();
    int busy = 0;
    int g0;
    g0 = got_q.size();
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      hold(1);
      if (rx_busy) busy++;
    end
    rx = 1'b1;
    for (int i = 0; i < 3 * BIT; i++) begin
      hold(1);
      if (rx_busy) busy++;
    end
    checks++;
    if (busy > 24 || busy == 0) begin
      errors++;
      $display("FAIL glitch_busy: got %0d busy cycles expected 1..24", busy);
    end
    checks++;
    if (got_q.size() != g0 || m_valid !== 1'b0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_nopush: got entries=%0d m_valid=%b rx_busy=%b expected 0 0 0",
               got_q.size() - g0, m_valid, rx_busy);
    end
  endtask

  task automatic test_clamp();
    logic [9:0] e;
    exp_q.push_back(model(8'hFF, 2, PAR_NONE, 1'b0, 1'b0, 2'b00));
    send_frame(8'hFF, 2, PAR_NONE, 1'b0, 1'b0, 2'b00, 1'b0);
    exp_q.push_back(model(8'hB7, 15, PAR_ODD, 1'b0, 1'b0, 2'b00));
    send_frame(8'hB7, 15, PAR_ODD, 1'b0, 1'b0, 2'b00, 1'b0);
    exp_q.push_back(model(8'hC3, 8, PAR_NONE, 1'b0, 1'b0, 2'b00));
    send_frame(8'hC3, 8, PAR_NONE, 1'b0, 1'b0, 2'b00, 1'b1);
    wait_entries(3, 2 * BIT);
    checks++;
    if (got_q.size() - got_rd != 3) begin
      errors++;
      $display("FAIL clamp_count: got %0d entries expected 3", got_q.size() - got_rd);
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[got_rd] !== e) begin
        errors++;
        $display("FAIL clamp_latch_entry: got %h expected %h", got_q[got_rd], e);
      end
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic test_stall();
    logic [7:0] v;
    logic [9:0] e;
    int k = 0;
    v = 8'($urandom_range(1, 255));
    e = model(v, 8, PAR_ODD, 1'b0, 1'b0, 2'b00);
    m_ready = 1'b0;
    send_frame(v, 8, PAR_ODD, 1'b0, 1'b0, 2'b00, 1'b0);
    while (!m_valid && k < 2 * BIT) begin
      hold(1);
      k++;
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({m_valid, m_data, m_parity_err, m_frame_err} !== {1'b1, e}) begin
        errors++;
        $display("FAIL stall_hold: got v=%b %h expected v=1 %h", m_valid,
                 {m_data, m_parity_err, m_frame_err}, e);
      end
      hold(1);
    end
    m_ready = 1'b1;
    hold(3);
    checks++;
    if (got_q.size() - got_rd != 1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_pop: got %0d entries m_valid=%b expected 1 0",
               got_q.size() - got_rd, m_valid);
    end
    got_rd = got_q.size();
  endtask

  task automatic test_overrun();
    int o0;
    logic [9:0] e;
    o0 = ovr_cnt;
    m_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(model(8'(v), 8, PAR_NONE, 1'b0, 1'b0, 2'b00));
      send_frame(8'(v), 8, PAR_NONE, 1'b0, 1'b0, 2'b00, 1'b0);
    end
    hold(4);
    checks++;
    if (ovr_cnt - o0 != 1) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d expected 1", ovr_cnt - o0);
    end
    m_ready = 1'b1;
    wait_entries(4, 50);
    hold(BIT);
    checks++;
    if (got_q.size() - got_rd != 4) begin
      errors++;
      $display("FAIL overrun_drain: got %0d entries expected 4", got_q.size() - got_rd);
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[got_rd] !== e) begin
        errors++;
        $display("FAIL overrun_order: got %h expected %h", got_q[got_rd], e);
      end
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic test_break();
    int b0;
    int g0;
    b0 = brk_cnt;
    g0 = got_q.size();
    num_data_bits = 4'd8;
    parity        = PAR_NONE;
    stop_bits     = STOP_1;
    rx = 1'b0;
    hold(1000);
    rx = 1'b1;
    hold(10 * BIT);
`ifdef UART_RX_BREAK_EN
    checks++;
    if (brk_cnt - b0 != 1 || got_q.size() != g0) begin
      errors++;
      $display("FAIL break_detect: got pulses=%0d entries=%0d expected 1 0",
               brk_cnt - b0, got_q.size() - g0);
    end
`else
    checks++;
    if (got_q.size() == g0 || brk_cnt != b0) begin
      errors++;
      $display("FAIL break_push: got entries=%0d pulses=%0d expected >=1 0",
               got_q.size() - g0, brk_cnt - b0);
    end else begin
      checks++;
      if (got_q[g0] !== {8'h00, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL break_entry: got %h expected %h", got_q[g0], {8'h00, 1'b0, 1'b1});
      end
    end
`endif
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL break_idle: rx_busy=%b expected 0", rx_busy);
    end
    got_rd = got_q.size();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v;
    v = 8'h3C;
    m_ready = 1'b0;
    send_frame(8'h11, 8, PAR_NONE, 1'b0, 1'b0, 2'b00, 1'b0);
    hold(4);
    num_data_bits = 4'd8;
    parity        = PAR_NONE;
    stop_bits     = STOP_1;
    rx = 1'b0;
    hold(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = v[i];
      hold(BIT);
    end
    rx = v[3];
    hold(BIT / 2);
    rst = 1'b1;
    hold(3);
    checks++;
    if (m_valid !== 1'b0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: m_valid=%b rx_busy=%b expected 0 0", m_valid, rx_busy);
    end
    rx = 1'b1;
    hold(2);
    rst = 1'b0;
    m_ready = 1'b1;
    hold(BIT);
    got_rd = got_q.size();
    send_frame(v, 8, PAR_NONE, 1'b0, 1'b0, 2'b00, 1'b0);
    wait_entries(1, 2 * BIT);
    hold(BIT);
    checks++;
    if (got_q.size() - got_rd != 1) begin
      errors++;
      $display("FAIL midreset_count: got %0d entries expected 1", got_q.size() - got_rd);
    end else begin
      checks++;
      if (got_q[got_rd] !== {8'h3C, 2'b00}) begin
        errors++;
        $display("FAIL midreset_entry: got %h expected %h", got_q[got_rd], {8'h3C, 2'b00});
      end
    end
    got_rd = got_q.size();
  endtask

  // Random framing; back_to_back drops the idle gap between frames.
  task automatic test_random(input int n, input logic back_to_back);
    logic [7:0] v;
    logic [9:0] e;
    logic [1:0] sl;
    logic       two, bad;
    int         nb;
    parity_t    par;
    for (int f = 0; f < n; f++) begin
      v   = 8'($urandom_range(0, 255));
      nb  = $urandom_range(3, 10);
      par = pick_par($urandom_range(0, 2));
      two = 1'($urandom_range(0, 1));
      bad = (par != PAR_NONE) && ($urandom_range(0, 2) == 0);
      sl  = 2'b00;
      // Stop errors only on non-zero data so the frame is never a break.
      if ((v & 8'((1 << eff_bits(nb)) - 1)) != 0 && $urandom_range(0, 3) == 0)
        sl = two ? 2'($urandom_range(1, 3)) : 2'b01;
      exp_q.push_back(model(v, nb, par, two, bad, sl));
      send_frame(v, nb, par, two, bad, sl, 1'b0);
      if (!back_to_back) hold($urandom_range(1, BIT));
    end
    wait_entries(n, 3 * BIT);
    hold(BIT);
    checks++;
    if (got_q.size() - got_rd != n) begin
      errors++;
      $display("FAIL random_count: got %0d entries expected %0d", got_q.size() - got_rd, n);
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[got_rd] !== e) begin
        errors++;
        $display("FAIL random_entry: got %h expected %h", got_q[got_rd], e);
      end
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst           = 1'b1;
    rx            = 1'b1;
    m_ready       = 1'b1;
    baud_div      = 16'(BDIV);
    num_data_bits = 4'd8;
    stop_bits     = STOP_1;
    parity        = PAR_NONE;
    test_reset();
    test_8n1();
    test_parity_7e2();
    test_glitch();
    test_clamp();
    test_stall();
    test_overrun();
    test_break();
    test_reset_mid_frame();
    test_random(10, 1'b0);
    test_random(4, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning ticks per bit period (even, at least 4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-frame buffer entries (power of 2, at least 2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning rx synchronizer flops (at least 2).
REQ-004 SHALL have ports, in order:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- rx, input, 1, asynchronous serial line; idle high.
- baud_div, input, 16, tick period in clk cycles, minus 1.
- num_data_bits, input, 4, data bits per frame; legal range 5..8.
- stop_bits, input, stop_bits_t, one or two stop bits.
- parity, input, parity_t, none, odd or even parity.
- m_data, output, 8, head entry data, right-aligned, unused upper bits 0.
- m_parity_err, output, 1, head entry parity error.
- m_frame_err, output, 1, head entry stop-bit error.
- m_valid, output, 1, head entry valid.
- m_ready, input, 1, consumer accepts head entry.
- rx_busy, output, 1, FSM not in S_IDLE.
- overrun, output, 1, one-cycle pulse when a frame is dropped.
- break_det, output, 1, one-cycle pulse when a break is detected.

Function
REQ-005 SHALL pass rx through SYNC_STAGES flops; all logic below uses the synchronized value.
REQ-006 SHALL generate a one-cycle tick every baud_div+1 clk cycles; baud_div=0 gives a tick every cycle; counter reloads in S_IDLE so the start edge aligns phase.
REQ-007 SHALL implement FSM states S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK.
REQ-008 S_IDLE: synchronized rx low -> S_START with tick count cleared.
REQ-009 S_START: at tick OVERSAMPLE/2, rx high -> S_IDLE (glitch, nothing pushed); rx low -> S_DATA.
REQ-010 At the start-bit sample, SHALL latch num_data_bits, stop_bits and parity; mid-frame input changes SHALL NOT affect the current frame.
REQ-011 SHALL clamp latched num_data_bits below 5 to 5 and above 8 to 8.
REQ-012 S_DATA: SHALL sample once every OVERSAMPLE ticks, LSB first, until the latched bit count is reached.
- Then -> S_PARITY if parity is not none, else S_STOP1.
REQ-013 S_PARITY: SHALL sample the parity bit.
- Parity error = XOR of data bits and parity bit is 0 for odd, or 1 for even.
REQ-014 S_STOP1: rx low at the sample SHALL set frame_err.
- With two stop bits -> S_STOP2, which samples again and ORs into frame_err.
REQ-015 At the final stop sample, SHALL push {data, parity_err, frame_err} into the FIFO and go to S_IDLE in the same cycle (next start accepted from mid-stop).
REQ-016 SHALL drive m_valid high exactly when the FIFO is non-empty; m_data and both error outputs are the head entry and stay stable while m_valid is high and m_ready is low.
REQ-017 SHALL pop the head when m_valid and m_ready are both high.
REQ-018 Push on a full FIFO with no pop that cycle SHALL drop the new frame, pulse overrun, and leave the FIFO unchanged.
REQ-019 Push and pop in the same cycle on a full FIFO SHALL accept the push, with no overrun.
REQ-020 Latency: m_valid SHALL rise 1 clk after the final stop sample.

Reset
REQ-021 While rst is high: FSM in S_IDLE; FIFO empty; m_valid, overrun, break_det, rx_busy = 0; m_data, m_parity_err, m_frame_err = 0; tick counter = 0; synchronizer flops = 1 (no false start).
REQ-022 Reset mid-frame SHALL discard the partial frame and all FIFO contents.

Configuration
REQ-023 SHALL implement break detection under macro UART_RX_BREAK_EN.
- Defined: a frame with all data bits 0, parity bit 0 (if enabled) and stop sample low SHALL NOT be pushed; it SHALL pulse break_det for 1 cycle, go to S_BREAK, and wait there until synchronized rx is high, then go to S_IDLE.
- Undefined: break_det tied 0; S_BREAK unreachable; such a frame is pushed with m_frame_err=1.

Structure
REQ-024 SHALL take parity_t and stop_bits_t from uart_pkg; SHALL add uart_rx_entry_t (data, parity_err, frame_err) and the state enum to uart_pkg.
REQ-025 SHALL instantiate the FIFO as sub-module uart_rx_fifo (parameters WIDTH, DEPTH; synchronous; full and empty flags; same-cycle push and pop).

Verification (OVERSAMPLE=16, baud_div=3, so 64 clk per bit)
REQ-026 Send 8N1 byte 0xA5 with m_ready=1 -> one beat of m_data=0xA5, both errors 0, no overrun.
REQ-027 Send 7 data bits, even parity, two stop bits, value 0x55 with a wrong parity bit -> m_data=0x55, m_parity_err=1.
REQ-028 Send a 20-clk low glitch on idle rx -> no push; FSM back in S_IDLE; rx_busy high for 24 clk or fewer.
REQ-029 Hold m_ready=0, send 5 frames 0x01..0x05 with FIFO_DEPTH=4 -> one overrun pulse; then m_ready=1 -> pops 0x01..0x04 in order.
REQ-030 Hold rx low for 1000 clk -> with UART_RX_BREAK_EN: break_det pulse, no push; without: entry 0x00 with m_frame_err=1.
REQ-031 Assert rst during data bit 3 of a frame, release, send 0x3C -> only 0x3C is delivered.
